// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Bridges a simple valid/ready command/response interface onto an APB
// requester. One transfer is in flight at a time: a command is accepted in
// IDLE, driven onto APB through SETUP and ACCESS, and its result is held in
// RESP until the consumer takes it.
//
// Optional feature (compile-time macro):
//   APB_MASTER_TIMEOUT_EN - bounds the number of wait states in ACCESS to
//                           TIMEOUT_CYCLES; an expired transfer completes
//                           with rsp_err = 1 and rsp_rdata = 0. Without the
//                           macro the block waits for pready indefinitely and
//                           carries no wait-state counter.
//
// Parameters:
//   ADDR_W         - APB address width
//   DATA_W         - APB data width
//   TIMEOUT_CYCLES - ACCESS wait-state limit (timeout build only)
//
// Ports:
//   pclk, preset         - clock (rising edge) and async active-high reset
//   cmd_valid/cmd_ready  - command handshake; cmd_ready is high only in IDLE
//   cmd_write            - 1 = write, 0 = read
//   cmd_addr, cmd_wdata  - transfer address and write data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - read data (0 for writes and failed transfers)
//   rsp_err              - transfer ended with pslverr or a timeout
//   psel, penable        - APB phase controls
//   pwrite, paddr,pwdata - APB transfer attributes, held outside transfers
//   prdata, pready,
//   pslverr              - APB completer response, sampled only in ACCESS
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // Acceptance is a pure decode of the state register, so a command can
    // only ever be taken while no transfer is in flight.
    assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    // Counts ACCESS cycles that saw pready = 0. The transfer is abandoned on
    // the wait-state cycle that brings the count to TIMEOUT_CYCLES, i.e. when
    // the counter already holds TIMEOUT_CYCLES - 1.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign timed_out = (wait_cnt == CNT_LAST);
`else
    // The wait-state limit has no effect in this build; it is referenced here
    // only so both builds share one parameter list.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // The command is captured here and the APB attribute
                    // outputs are loaded directly, so they stay stable for
                    // the whole transfer whatever the command port does.
                    if (cmd_valid) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                ACCESS: begin
                    if (pready) begin
                        state     <= RESP;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        // Only a successful read returns data; writes and
                        // failed reads report zero.
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timed_out) begin
                        state     <= RESP;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end

                // NOTE: unreachable with a two-bit encoding of four states,
                // but it keeps the case complete and recovers to IDLE.
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Self-checking bench for apb_master. A behavioural APB completer with a
// small word memory answers transfers with a configurable number of wait
// states and an optional slave error; outside ACCESS it drives random noise
// on pready/pslverr/prdata. Expected responses come from a separate model
// memory updated from the commands the bench issues, plus latency figures
// derived from the handshake timing rules.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic              pclk      = 1'b0;
    logic              preset    = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_ready = 1'b0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Completer configuration for the transfer in progress.
    int          cfg_waits  = 0;
    logic        cfg_err    = 1'b0;
    logic        mem_clear  = 1'b0;
    int          acc_cycles = 0;
    logic        noise_ready = 1'b0;
    logic        noise_err   = 1'b0;
    logic [31:0] noise_data  = '0;
    logic        in_access;

    logic [31:0] resp_mem  [16];
    logic [31:0] model_mem [16];

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    // ---------------- behavioural completer ----------------
    assign in_access = psel && penable;
    assign pready    = in_access ? (acc_cycles >= cfg_waits) : noise_ready;
    assign pslverr   = in_access ? cfg_err : noise_err;
    assign prdata    = in_access ? resp_mem[paddr[3:0]] : noise_data;

    always @(posedge pclk) begin
        cycle       <= cycle + 1;
        noise_ready <= 1'($urandom_range(1, 0));
        noise_err   <= 1'($urandom_range(1, 0));
        noise_data  <= $urandom();
        acc_cycles  <= (in_access && !pready) ? acc_cycles + 1 : 0;
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) resp_mem[i] <= 32'hC0DE0000 | 32'(i);
        end else if (in_access && pready && pwrite && !pslverr) begin
            resp_mem[paddr[3:0]] <= pwdata;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 preset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        preset = 1'b0;
    endtask

    // Runs one transfer and reports what was observed; protocol deviations
    // seen along the way are tallied in viol for the caller to judge.
    task automatic run_xfer(
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          waits,
        input  logic        err,
        input  int          hold,
        input  logic        noisy_cmd,
        output logic [31:0] rdata,
        output logic        rerr,
        output int          latency,
        output int          setups,
        output int          accesses,
        output int          viol,
        output int          hs_cycle,
        output logic        hung
    );
        int n;
        cfg_waits = waits;
        cfg_err   = err;
        rdata = '0; rerr = 1'b0; latency = 0; setups = 0; accesses = 0;
        viol = 0; hs_cycle = 0; hung = 1'b0;

        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        hs_cycle  = cycle;
        tick();
        // Scramble the command port: the DUT must work from its captured copy.
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;

        n = 1;
        while (rsp_valid !== 1'b1 && n <= 200) begin
            if (psel === 1'b1 && penable === 1'b0) setups++;
            if (penable === 1'b1) accesses++;
            if (penable === 1'b1 && psel !== 1'b1) viol++;
            if (psel === 1'b1 && (paddr !== addr || pwrite !== wr || pwdata !== wdata)) viol++;
            if (cmd_ready !== 1'b0) viol++;
            tick();
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            hung = 1'b1;
            pulse_reset();
            return;
        end
        latency = n;
        rdata   = rsp_rdata;
        rerr    = rsp_err;
        if (psel !== 1'b0 || penable !== 1'b0) viol++;

        if (noisy_cmd) begin
            cmd_valid = 1'b1;
            cmd_write = ~wr;
            cmd_addr  = $urandom();
            cmd_wdata = $urandom();
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== rerr ||
                cmd_ready !== 1'b0 || psel !== 1'b0) viol++;
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) viol++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        preset = 1'b0;
        #2 preset = 1'b1;
        mem_clear = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'hC0DE0000 | 32'(i);
        #1;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h expected all 0", paddr, pwdata, rsp_rdata);
        end
        tick();
        tick();
        mem_clear = 1'b0;
        preset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b psel=%b rsp_valid=%b expected 1 0 0", cmd_ready, psel, rsp_valid);
        end
    endtask

    task automatic test_write();
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs;
        run_xfer(1'b1, 32'h5, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        model_mem[5] = 32'hDEADBEEF;
        checks++;
        if (hung !== 1'b0 || lat != 3 || su != 1 || ac != 1) begin
            errors++;
            $display("FAIL write_timing: got hung=%b lat=%0d setup=%0d access=%0d expected 0 3 1 1", hung, lat, su, ac);
        end
        checks++;
        if (rd !== 32'h0 || re !== 1'b0 || vi != 0) begin
            errors++;
            $display("FAIL write_rsp: got rdata=%h err=%b viol=%0d expected 0 0 0", rd, re, vi);
        end
    endtask

    task automatic test_read_wait();
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs;
        run_xfer(1'b0, 32'h5, 32'h1234, 3, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        checks++;
        if (hung !== 1'b0 || ac != 4 || lat != 6 || vi != 0) begin
            errors++;
            $display("FAIL read_wait_timing: got hung=%b access=%0d lat=%0d viol=%0d expected 0 4 6 0", hung, ac, lat, vi);
        end
        checks++;
        if (rd !== model_mem[5] || re !== 1'b0) begin
            errors++;
            $display("FAIL read_wait_rsp: got rdata=%h err=%b expected %h 0", rd, re, model_mem[5]);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs;
        run_xfer(1'b0, 32'h40, 32'h0, 0, 1'b1, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        checks++;
        if (rd !== 32'h0 || re !== 1'b1) begin
            errors++;
            $display("FAIL slverr_rsp: got rdata=%h err=%b expected 0 1", rd, re);
        end
        checks++;
        if (hung !== 1'b0 || lat != 3 || vi != 0) begin
            errors++;
            $display("FAIL slverr_timing: got hung=%b lat=%0d viol=%0d expected 0 3 0", hung, lat, vi);
        end
        // A failed write must not reach the completer's memory.
        run_xfer(1'b1, 32'h7, 32'hBAD0BAD0, 1, 1'b1, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        run_xfer(1'b0, 32'h7, 32'h0, 0, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        checks++;
        if (rd !== model_mem[7]) begin
            errors++;
            $display("FAIL slverr_write_dropped: got %h expected %h", rd, model_mem[7]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs;
        run_xfer(1'b0, 32'h5, 32'h0, 1, 1'b0, 5, 1'b1, rd, re, lat, su, ac, vi, hs, hung);
        checks++;
        if (hung !== 1'b0 || vi != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got hung=%b viol=%0d expected 0 0", hung, vi);
        end
        checks++;
        if (rd !== model_mem[5] || re !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_rsp: got rdata=%h err=%b expected %h 0", rd, re, model_mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs1, hs2;
        run_xfer(1'b1, 32'h3, 32'hA1A2A3A4, 0, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs1, hung);
        model_mem[3] = 32'hA1A2A3A4;
        run_xfer(1'b0, 32'h3, 32'h0, 0, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs2, hung);
        checks++;
        if (hs2 - hs1 != 4) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d cycles expected 4", hs2 - hs1);
        end
        checks++;
        if (rd !== 32'hA1A2A3A4) begin
            errors++;
            $display("FAIL back_to_back_data: got %h expected a1a2a3a4", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd; logic re, hung, wr, err;
        int lat, su, ac, vi, hs, waits, hold;
        for (int t = 0; t < 40; t++) begin
            wr    = 1'($urandom_range(1, 0));
            addr  = $urandom();
            wdata = $urandom();
            waits = int'($urandom_range(3, 0));
            err   = ($urandom_range(7, 0) == 0);
            hold  = int'($urandom_range(2, 0));
            exp_rd = (wr || err) ? 32'h0 : model_mem[addr[3:0]];
            if (wr && !err) model_mem[addr[3:0]] = wdata;
            run_xfer(wr, addr, wdata, waits, err, hold, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
            checks++;
            if (rd !== exp_rd || re !== err) begin
                errors++;
                $display("FAIL random_rsp[%0d]: got rdata=%h err=%b expected %h %b", t, rd, re, exp_rd, err);
            end
            checks++;
            if (hung !== 1'b0 || lat != 3 + waits || ac != waits + 1 || vi != 0) begin
                errors++;
                $display("FAIL random_timing[%0d]: got hung=%b lat=%0d access=%0d viol=%0d expected 0 %0d %0d 0",
                         t, hung, lat, ac, vi, 3 + waits, waits + 1);
            end
        end
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        logic [31:0] rd; logic re, hung; int lat, su, ac, vi, hs;
        run_xfer(1'b0, 32'h5, 32'h0, 100000, 1'b0, 0, 1'b0, rd, re, lat, su, ac, vi, hs, hung);
        checks++;
        if (hung !== 1'b0 || ac != TIMEOUT_CYCLES || lat != TIMEOUT_CYCLES + 2) begin
            errors++;
            $display("FAIL timeout_timing: got hung=%b access=%0d lat=%0d expected 0 %0d %0d",
                     hung, ac, lat, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 2);
        end
        checks++;
        if (rd !== 32'h0 || re !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: got rdata=%h err=%b expected 0 1", rd, re);
        end
`else
        int bad;
        cfg_waits = 100000;
        cfg_err   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h5;
        tick();
        cmd_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(psel === 1'b1 && penable === 1'b1 && rsp_valid === 1'b0)) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || penable !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_wait: got %0d cycles outside ACCESS, penable=%b expected 0 1", bad, penable);
        end
        cfg_waits = 0;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== model_mem[5]) begin
            errors++;
            $display("FAIL no_timeout_finish: got valid=%b err=%b rdata=%h expected 1 0 %h",
                     rsp_valid, rsp_err, rsp_rdata, model_mem[5]);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_access();
        int leaks;
        cfg_waits = 100000;
        cfg_err   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h9;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_setup: got psel=%b penable=%b expected 1 1", psel, penable);
        end
        #2 preset = 1'b1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got psel=%b penable=%b rsp_valid=%b expected 0 0 0", psel, penable, rsp_valid);
        end
        tick();
        preset = 1'b0;
        cfg_waits = 0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
        leaks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            errors++;
            $display("FAIL abandoned_transfer: got %0d cycles with activity expected 0", leaks);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, wait-state limit in ACCESS (used only with APB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have port pclk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port preset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  transfer address.
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data (0 for writes and errors).
REQ-014 SHALL have port rsp_err  output  1  transfer ended with pslverr or timeout.
REQ-015 SHALL have ports psel, penable, pwrite (output, 1 each), paddr (output, ADDR_W), pwdata (output, DATA_W), prdata (input, DATA_W), pready, pslverr (input, 1 each), forming the APB requester side.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE; a handshake in IDLE captures cmd_write/addr/wdata and moves to SETUP.
REQ-018 SHALL, in SETUP, drive psel=1, penable=0, paddr/pwrite/pwdata from the captured command, then move to ACCESS unconditionally after one cycle.
REQ-019 SHALL, in ACCESS, drive psel=1, penable=1 with paddr/pwrite/pwdata unchanged, and remain in ACCESS while pready=0.
REQ-020 SHALL, on pready=1 in ACCESS, capture rsp_err=pslverr and rsp_rdata=prdata for a read with pslverr=0 (else 0), deassert psel/penable the next cycle, and move to RESP.
REQ-021 SHALL, in RESP, hold rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE with rsp_valid=0.
REQ-022 SHALL give minimum latency cmd handshake -> rsp_valid of 3 cycles (SETUP, ACCESS with pready=1, RESP asserted); minimum 4 cycles between successive cmd handshakes.
REQ-023 SHALL ignore cmd_valid outside IDLE and ignore pready/pslverr/prdata outside ACCESS.
REQ-024 SHALL drive psel=0 and penable=0 in IDLE and RESP; paddr/pwrite/pwdata hold last values there.

Reset
REQ-025 SHALL, on preset=1, immediately (asynchronously) force state IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter to 0.
REQ-026 SHALL, on reset in SETUP/ACCESS/RESP, abandon the transfer with no response generated; cmd_ready=1 on the first clock after preset falls.

Configuration
REQ-027 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles with pready=0; when the count reaches TIMEOUT_CYCLES, end the transfer as in REQ-020 with rsp_err=1, rsp_rdata=0; counter clears on entering ACCESS.
REQ-028 SHALL, without APB_MASTER_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely for pready.

Verification
REQ-029 Write addr 0x5, data 0xDEADBEEF, pready=1 at first ACCESS -> SETUP then ACCESS each 1 cycle with paddr=0x5, pwrite=1, pwdata=0xDEADBEEF; rsp_valid 3 cycles after handshake, rsp_err=0, rsp_rdata=0.
REQ-030 Read addr 0x5 with responder returning prdata=0xDEADBEEF after 3 wait states -> penable held 4 cycles, paddr stable; rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 Read addr 0x40, responder pslverr=1 with pready -> rsp_err=1, rsp_rdata=0; psel=0 next cycle.
REQ-032 rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata, rsp_err stable 5 cycles, cmd_ready=0 throughout, cmd_valid ignored.
REQ-033 preset pulsed mid-ACCESS -> psel/penable/rsp_valid 0 without waiting for a clock edge, no response emitted, cmd_ready=1 first cycle after release.
REQ-034 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready tied 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0; without macro, still in ACCESS after 100 cycles.
